// File: rtl/ps2_cmd_scheduler_if.sv
// Bundles for the PS/2 command scheduler: the requester side (commands in, status out)
// and the device side (byte transport to and from the keyboard).
interface ps2_cmd_req_if;
  logic [1:0]  req_valid;
  logic [15:0] req_cmd;
  logic [1:0]  req_has_param;
  logic [15:0] req_param;
  logic [1:0]  req_ready;
  logic        done;
  logic        done_id;
  logic        done_err;
  logic        active;

  modport master (
    output req_valid, req_cmd, req_has_param, req_param,
    input  req_ready, done, done_id, done_err, active
  );
  modport slave (
    input  req_valid, req_cmd, req_has_param, req_param,
    output req_ready, done, done_id, done_err, active
  );
endinterface

interface ps2_cmd_dev_if;
  logic       dev_write;
  logic [7:0] dev_tx_data;
  logic       dev_busy;
  logic       dev_read;
  logic [7:0] dev_rx_data;

  modport master (
    output dev_write, dev_tx_data,
    input  dev_busy, dev_read, dev_rx_data
  );
  modport slave (
    input  dev_write, dev_tx_data,
    output dev_busy, dev_read, dev_rx_data
  );
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// Round-robin scheduler for host-to-keyboard PS/2 commands: sends a command byte and an
// optional parameter byte, waits for ACK after each, retries on RESEND or timeout.
module ps2_cmd_scheduler #(
  parameter int ACK_TIMEOUT = 502500,
  parameter int MAX_RETRIES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_cmd_req_if.slave  req,
  ps2_cmd_dev_if.master dev
);
  localparam int RW = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;

  typedef enum logic [2:0] {IDLE, SEND, TX_START, TX_END, ACK_WAIT, DONE} state_t;
  typedef enum logic {PH_CMD, PH_PARAM} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    param_q, param_d;
  logic          has_param_q, has_param_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [1:0]    req_ready_q, req_ready_d;
  logic          done_q, done_d;
  logic          done_id_q, done_id_d;
  logic          done_err_q, done_err_d;
  logic          active_q, active_d;
  logic          dev_write_q, dev_write_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          sel;
  logic          retry;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    param_d      = param_q;
    has_param_d  = has_param_q;
    retries_d    = retries_q;
    timer_d      = timer_q;
    err_d        = err_q;
    tx_data_d    = tx_data_q;
    req_ready_d  = 2'b00;
    dev_write_d  = 1'b0;
    sel          = 1'b0;
    retry        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req.req_valid) begin
          // With both requesting, the one not served last time wins.
          sel          = (&req.req_valid) ? ~last_grant_q : req.req_valid[1];
          gnt_d        = sel;
          last_grant_d = sel;
          cmd_d        = sel ? req.req_cmd[15:8]   : req.req_cmd[7:0];
          param_d      = sel ? req.req_param[15:8] : req.req_param[7:0];
          has_param_d  = req.req_has_param[sel];
          req_ready_d  = sel ? 2'b10 : 2'b01;
          phase_d      = PH_CMD;
          retries_d    = '0;
          err_d        = 1'b0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (!dev.dev_busy) begin
          dev_write_d = 1'b1;
          tx_data_d   = (phase_q == PH_PARAM) ? param_q : cmd_q;
          state_d     = TX_START;
        end
      end
      TX_START: begin
        if (dev.dev_busy) state_d = TX_END;
      end
      TX_END: begin
        if (!dev.dev_busy) begin
          timer_d = '0;
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (dev.dev_read && dev.dev_rx_data == RSP_ACK) begin
          if (phase_q == PH_CMD && has_param_q) begin
            phase_d   = PH_PARAM;
            retries_d = '0;
            state_d   = SEND;
          end else begin
            err_d   = 1'b0;
            state_d = DONE;
          end
        end else if (dev.dev_read && dev.dev_rx_data == RSP_RESEND) begin
          retry = 1'b1;
        end else if (dev.dev_read && dev.dev_rx_data == RSP_ERROR) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          retry = 1'b1;
        end
        // Unrecognised bytes fall through so the timer keeps running.
        if (retry) begin
          if (retries_q < RETRY_MAX) begin
            retries_d = retries_q + 1'b1;
            state_d   = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_d   = (state_d != IDLE);
    done_d     = (state_d == DONE);
    done_id_d  = done_d & gnt_d;
    done_err_d = done_d & err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_CMD;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cmd_q        <= '0;
      param_q      <= '0;
      has_param_q  <= 1'b0;
      retries_q    <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 2'b00;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      done_err_q   <= 1'b0;
      active_q     <= 1'b0;
      dev_write_q  <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      param_q      <= param_d;
      has_param_q  <= has_param_d;
      retries_q    <= retries_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
      active_q     <= active_d;
      dev_write_q  <= dev_write_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign req.req_ready   = req_ready_q;
  assign req.done        = done_q;
  assign req.done_id     = done_id_q;
  assign req.done_err    = done_err_q;
  assign req.active      = active_q;
  assign dev.dev_write   = dev_write_q;
  assign dev.dev_tx_data = tx_data_q;
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: two instances (MAX_RETRIES 3 and 1, short timeout) driven
// by a keyboard model that answers from a per-instance script of response bytes.
module tb_ps2_cmd_scheduler;
  localparam logic [9:0] A_ACK    = 10'h0FA;
  localparam logic [9:0] A_RESEND = 10'h0FE;
  localparam logic [9:0] A_ERROR  = 10'h0FC;
  localparam logic [9:0] A_SILENT = 10'h100;
  localparam logic [9:0] A_NOISY  = 10'h2FA;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  req_valid_t     [2] = '{2'b00, 2'b00};
  logic [15:0] req_cmd_t       [2] = '{16'h0, 16'h0};
  logic [1:0]  req_has_param_t [2] = '{2'b00, 2'b00};
  logic [15:0] req_param_t     [2] = '{16'h0, 16'h0};
  logic        force_busy = 1'b0;

  wire [1:0] ready_w    [2];
  wire       done_w     [2];
  wire       done_id_w  [2];
  wire       done_err_w [2];
  wire       active_w   [2];
  wire       write_w    [2];
  wire [7:0] txd_w      [2];

  // Answer script per instance: bit8 = stay silent, bit9 = send a stray 0xAA first.
  logic [9:0] resp_q  [2][$];
  int         wr_cyc  [2][$];
  logic [7:0] wr_byte [2][$];

  int checks = 0;
  int failures = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ps2_cmd_req_if rq ();
    ps2_cmd_dev_if dv ();
    logic       busy_m = 1'b0;
    logic       read_m = 1'b0;
    logic [7:0] rx_m   = 8'h00;

    assign rq.req_valid     = req_valid_t[k];
    assign rq.req_cmd       = req_cmd_t[k];
    assign rq.req_has_param = req_has_param_t[k];
    assign rq.req_param     = req_param_t[k];
    assign dv.dev_busy      = busy_m | ((k == 0) ? force_busy : 1'b0);
    assign dv.dev_read      = read_m;
    assign dv.dev_rx_data   = rx_m;
    assign ready_w[k]       = rq.req_ready;
    assign done_w[k]        = rq.done;
    assign done_id_w[k]     = rq.done_id;
    assign done_err_w[k]    = rq.done_err;
    assign active_w[k]      = rq.active;
    assign write_w[k]       = dv.dev_write;
    assign txd_w[k]         = dv.dev_tx_data;

    ps2_cmd_scheduler #(.ACK_TIMEOUT(100), .MAX_RETRIES((k == 0) ? 3 : 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (rq),
      .dev   (dv)
    );

    initial begin : keyboard
      logic [9:0] r;
      forever begin
        @(posedge clk); #1;
        if (dv.dev_write === 1'b1) begin
          wr_cyc[k].push_back(cyc);
          wr_byte[k].push_back(dv.dev_tx_data);
          busy_m = 1'b1;
          repeat ($urandom_range(2, 6)) @(posedge clk);
          #1 busy_m = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          if (resp_q[k].size() > 0) begin
            r = resp_q[k].pop_front();
            if (r[9]) begin
              rx_m = 8'hAA; read_m = 1'b1;
              @(posedge clk); #1 read_m = 1'b0;
              @(posedge clk); #1;
            end
            if (!r[8]) begin
              rx_m = r[7:0]; read_m = 1'b1;
              @(posedge clk); #1 read_m = 1'b0;
            end
          end
        end
      end
    end
  end

  // Byte-level view of a transaction: every attempt writes the byte and consumes one answer.
  function automatic void predict(input int maxr, input logic [7:0] cmd, input logic hp,
                                  input logic [7:0] prm, input logic [9:0] ans[$],
                                  output logic [7:0] ew[$], output logic eerr, output int used);
    logic [7:0] bytes_q[$];
    logic [9:0] a;
    int tries;
    bytes_q = {cmd};
    if (hp) bytes_q.push_back(prm);
    ew = {};
    eerr = 1'b0;
    used = 0;
    foreach (bytes_q[b]) begin
      tries = 0;
      forever begin
        ew.push_back(bytes_q[b]);
        a = (used < ans.size()) ? ans[used] : A_SILENT;
        used++;
        if (!a[8] && a[7:0] == 8'hFA) break;
        if (!a[8] && a[7:0] == 8'hFC) begin eerr = 1'b1; return; end
        if (tries == maxr) begin eerr = 1'b1; return; end
        tries++;
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int k, input int id, input logic [7:0] cmd, input logic hp,
                         input logic [7:0] prm, input logic [9:0] ans[$], input string tag);
    logic [7:0] ew[$];
    logic eerr;
    int used;
    int t;
    logic [1:0] want_rdy;
    predict((k == 0) ? 3 : 1, cmd, hp, prm, ans, ew, eerr, used);
    resp_q[k].delete();
    for (int i = 0; i < used && i < ans.size(); i++) resp_q[k].push_back(ans[i]);
    wr_byte[k].delete();
    wr_cyc[k].delete();
    want_rdy = (id == 1) ? 2'b10 : 2'b01;
    req_cmd_t[k][id*8 +: 8]   = cmd;
    req_param_t[k][id*8 +: 8] = prm;
    req_has_param_t[k][id]    = hp;
    req_valid_t[k][id]        = 1'b1;
    t = 0;
    while (ready_w[k] === 2'b00 && t < 50) begin step(1); t++; end
    checks++;
    if (ready_w[k] !== want_rdy || active_w[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s grant: req_ready=%b active=%b, want req_ready=%b active=1",
               tag, ready_w[k], active_w[k], want_rdy);
    end
    req_valid_t[k][id] = 1'b0;
    step(1);
    checks++;
    if (ready_w[k] !== 2'b00) begin
      failures++;
      $display("FAIL %s ready_pulse: req_ready=%b, want 00", tag, ready_w[k]);
    end
    t = 0;
    while (done_w[k] !== 1'b1 && t < 3000) begin step(1); t++; end
    checks++;
    if (done_w[k] !== 1'b1 || done_id_w[k] !== id[0] || done_err_w[k] !== eerr ||
        active_w[k] !== 1'b1) begin
      failures++;
      $display("FAIL %s done: done=%b id=%b err=%b active=%b, want done=1 id=%0d err=%b active=1",
               tag, done_w[k], done_id_w[k], done_err_w[k], active_w[k], id, eerr);
    end
    step(1);
    checks++;
    if (done_w[k] !== 1'b0 || active_w[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b active=%b, want 0 0", tag, done_w[k], active_w[k]);
    end
    checks++;
    if (wr_byte[k].size() != ew.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d, want %0d", tag, wr_byte[k].size(), ew.size());
    end else begin
      foreach (ew[i]) begin
        checks++;
        if (wr_byte[k][i] !== ew[i]) begin
          failures++;
          $display("FAIL %s write_byte[%0d]: got %h, want %h", tag, i, wr_byte[k][i], ew[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid_t[0]     = 2'b11;
    req_cmd_t[0]       = 16'hF5F4;
    req_has_param_t[0] = 2'b00;
    step(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ready_w[k], done_w[k], done_id_w[k], done_err_w[k], active_w[k], write_w[k],
           txd_w[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: rdy=%b done=%b id=%b err=%b act=%b wr=%b tx=%h, want all 0",
                 k, ready_w[k], done_w[k], done_id_w[k], done_err_w[k], active_w[k], write_w[k],
                 txd_w[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic last_m;
    logic exp_g;
    logic [7:0] exp_bytes[$];
    logic [1:0] rdy;
    int g;
    int t;
    last_m = 1'b1;
    wr_byte[0].delete();
    wr_cyc[0].delete();
    resp_q[0].delete();
    repeat (4) resp_q[0].push_back(A_ACK);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_g = (req_valid_t[0] == 2'b11) ? ~last_m : req_valid_t[0][1];
      t = 0;
      while (ready_w[0] === 2'b00 && t < 100) begin step(1); t++; end
      rdy = ready_w[0];
      checks++;
      if (rdy !== (exp_g ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, want %b", n, rdy, exp_g ? 2'b10 : 2'b01);
      end
      g = int'(exp_g);
      last_m = exp_g;
      exp_bytes.push_back(exp_g ? 8'hF5 : 8'hF4);
      req_valid_t[0][g] = 1'b0;
      t = 0;
      while (done_w[0] !== 1'b1 && t < 1000) begin step(1); t++; end
      checks++;
      if (done_w[0] !== 1'b1 || done_id_w[0] !== exp_g || done_err_w[0] !== 1'b0) begin
        failures++;
        $display("FAIL rr_done[%0d]: done=%b id=%b err=%b, want 1 %b 0",
                 n, done_w[0], done_id_w[0], done_err_w[0], exp_g);
      end
      if (n < 2) req_valid_t[0][g] = 1'b1;
      step(1);
    end
    checks++;
    if (wr_byte[0].size() != 4) begin
      failures++;
      $display("FAIL rr_write_count: got %0d, want 4", wr_byte[0].size());
    end else begin
      foreach (exp_bytes[i]) begin
        checks++;
        if (wr_byte[0][i] !== exp_bytes[i]) begin
          failures++;
          $display("FAIL rr_write_byte[%0d]: got %h, want %h", i, wr_byte[0][i], exp_bytes[i]);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [9:0] ans[$];
    ans = {A_ACK};
    run_txn(0, 0, 8'hF4, 1'b0, 8'h00, ans, "enable_req0");
    ans = {A_ACK, A_ACK};
    run_txn(0, 1, 8'hED, 1'b1, 8'h04, ans, "led_req1");
    ans = {A_RESEND, A_RESEND, A_ACK, A_ACK};
    run_txn(0, 0, 8'hED, 1'b1, 8'h04, ans, "resend_recover");
    run_txn(1, 0, 8'hED, 1'b1, 8'h04, ans, "resend_limit1");
    ans = {A_ERROR};
    run_txn(0, 1, 8'hF5, 1'b0, 8'h00, ans, "error_byte");
    ans = {A_NOISY, A_NOISY};
    run_txn(0, 1, 8'hF0, 1'b1, 8'h02, ans, "stray_byte");
  endtask

  task automatic test_timeout();
    logic [9:0] ans[$];
    ans = {};
    run_txn(0, 0, 8'hF3, 1'b1, 8'h20, ans, "timeout");
    for (int i = 1; i < wr_cyc[0].size(); i++) begin
      checks++;
      if (wr_cyc[0][i] - wr_cyc[0][i-1] < 100) begin
        failures++;
        $display("FAIL timeout_spacing[%0d]: got %0d cycles, want >= 100",
                 i, wr_cyc[0][i] - wr_cyc[0][i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] ans[$];
    int p;
    for (int n = 0; n < 20; n++) begin
      ans.delete();
      for (int j = 0; j < 8; j++) begin
        p = $urandom_range(0, 99);
        if (p < 65)      ans.push_back(A_ACK);
        else if (p < 77) ans.push_back(A_RESEND);
        else if (p < 82) ans.push_back(A_ERROR);
        else if (p < 87) ans.push_back(A_SILENT);
        else             ans.push_back(A_NOISY);
      end
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 1'($urandom_range(0, 1)),
              8'($urandom), ans, "random");
    end
  endtask

  task automatic test_reset_mid();
    int t;
    resp_q[0].delete();
    wr_byte[0].delete();
    wr_cyc[0].delete();
    req_cmd_t[0][7:0]      = 8'hF2;
    req_has_param_t[0][0]  = 1'b0;
    req_valid_t[0][0]      = 1'b1;
    t = 0;
    while (wr_byte[0].size() == 0 && t < 50) begin step(1); t++; end
    req_valid_t[0][0] = 1'b0;
    step(15);
    force_busy = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_w[0], done_w[0], done_id_w[0], done_err_w[0], active_w[0], write_w[0],
         txd_w[0]} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%b done=%b act=%b wr=%b tx=%h, want all 0",
               ready_w[0], done_w[0], active_w[0], write_w[0], txd_w[0]);
    end
    step(2);
    rst_n = 1'b1;
    wr_byte[0].delete();
    wr_cyc[0].delete();
    resp_q[0].push_back(A_ACK);
    req_cmd_t[0][7:0] = 8'hF3;
    req_valid_t[0][0] = 1'b1;
    t = 0;
    while (ready_w[0] === 2'b00 && t < 50) begin step(1); t++; end
    req_valid_t[0][0] = 1'b0;
    step(20);
    checks++;
    if (wr_byte[0].size() != 0) begin
      failures++;
      $display("FAIL midreset_hold: got %0d writes while busy, want 0", wr_byte[0].size());
    end
    force_busy = 1'b0;
    t = 0;
    while (done_w[0] !== 1'b1 && t < 500) begin step(1); t++; end
    checks++;
    if (done_w[0] !== 1'b1 || done_err_w[0] !== 1'b0 || wr_byte[0].size() != 1) begin
      failures++;
      $display("FAIL midreset_resume: done=%b err=%b writes=%0d, want 1 0 1",
               done_w[0], done_err_w[0], wr_byte[0].size());
    end else begin
      checks++;
      if (wr_byte[0][0] !== 8'hF3) begin
        failures++;
        $display("FAIL midreset_byte: got %h, want f3", wr_byte[0][0]);
      end
    end
    step(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
- Sequences host-to-keyboard commands over the PS/2 device transport: LED updates, enable, reset and typematic commands.
- Arbitrates two command requesters round-robin, for example the caps-lock LED logic and the init/self-test logic.
- Sends the command byte and an optional parameter byte, and waits for ACK (0xFA) after each byte.
- Retries on RESEND (0xFE) or timeout, then reports completion status to the granted requester.

Parameters:
- ACK_TIMEOUT, 502500, cycles to wait for a response byte after a transmit completes (20 ms at 25.125 MHz).
- MAX_RETRIES, 3, resends allowed per byte before failure.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command request; level, held with payload until req_ready
- req_cmd  in  16  {cmd1, cmd0}; command byte per requester
- req_has_param  in  2  per requester; 1 = a parameter byte follows the command
- req_param  in  16  {param1, param0}
- req_ready  out  2  one-cycle pulse; payload captured, requester drops req_valid
- done  out  1  one-cycle pulse; transaction finished
- done_id  out  1  requester index for done; valid while done=1
- done_err  out  1  with done: 1 = failed (0xFC, or retries exhausted)
- active  out  1  high from capture until the done pulse inclusive
- dev_write  out  1  one-cycle write strobe to the PS/2 device
- dev_tx_data  out  8  byte to transmit; stable from the strobe until transmit completes
- dev_busy  in  1  PS/2 device busy (rx or tx)
- dev_read  in  1  one-cycle pulse; dev_rx_data valid
- dev_rx_data  in  8  received byte

Behaviour:
- Reset values: all outputs 0, state IDLE, last-grant pointer 1 (requester 0 wins first), retry count 0, timer 0.
- Reset is asserted asynchronously. The device itself has no reset, so after release the first write still waits for dev_busy=0.
- IDLE: if any req_valid bit is set, grant round-robin.
  - Both set: grant the index not equal to last_grant.
  - Same cycle: capture cmd/has_param/param, pulse req_ready[g], set last_grant=g, active=1, phase=CMD, retries=0, go to SEND.
- SEND: while dev_busy=1, hold. On dev_busy=0: dev_write=1 for one cycle, dev_tx_data = cmd (phase CMD) or param (phase PARAM), go to TX_START.
- TX_START: wait for dev_busy=1, then go to TX_END. A receive started by the keyboard first is tolerated, because busy also covers rx.
- TX_END: wait for dev_busy=0; clear timer; go to ACK_WAIT.
- ACK_WAIT: timer increments each cycle. On dev_read:
  - 0xFA, phase CMD and has_param: phase=PARAM, retries=0, go to SEND.
  - 0xFA otherwise: go to DONE with err=0.
  - 0xFE: retry.
  - 0xFC: go to DONE with err=1.
  - Any other byte: ignored; timer keeps running.
- Timeout: timer reaching ACK_TIMEOUT-1 without a decisive byte counts as a retry.
- Retry: if retries < MAX_RETRIES, increment retries and go to SEND with the same byte; else go to DONE with err=1.
- DONE: done=1, done_id=g, done_err as set, active=1 this cycle, then IDLE with active=0.
- New grants happen only in IDLE. A req_valid rising mid-transaction waits and is never lost.
- Retry counter is 2 bits wide minimum, sized for MAX_RETRIES. Timer is $clog2(ACK_TIMEOUT)+1 bits.
- dev_read outside ACK_WAIT is ignored; those bytes go to the scan-code path, not here.

Test Plan:
- Requester 0: cmd 0xF4, no param; device answers 0xFA -> req_ready=01 one cycle, one dev_write with data 0xF4, done=1, done_id=0, done_err=0.
- Requester 1: cmd 0xED, param 0x04; answers FA, FA -> two writes (0xED then 0x04), single done pulse with done_id=1, done_err=0.
- Both req_valid asserted from reset and re-asserted after each done -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- Answers FE, FE, FA to cmd 0xED -> three writes of 0xED, then param sent, done_err=0. With MAX_RETRIES=1 the same stimulus -> done_err=1 after two writes.
- No response (ACK_TIMEOUT=100) -> 1+MAX_RETRIES writes spaced ≥100 cycles apart, then done_err=1. Answer 0xFC -> done_err=1 immediately, no retry.
- rst_n pulsed low in ACK_WAIT while dev_busy=1 -> outputs 0 at once; after release, no dev_write until dev_busy=0.
